multdiv_unit: RTL and testbench

MULTDIV_UNIT -- requirements
Module: multdiv_unit

---
 rtl/multdiv_unit.sv | 155 +++++++++++++++
 tb/tb_multdiv_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide unit.
// Multiply: 32 shift-add steps (last step subtracts, MSB weight is -2^31).
// Divide: 32 restoring shift-subtract steps on magnitudes, then sign fix.
// Ports:
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   data_operandA/B              : signed operands, latched on the start edge
//   ctrl_MULT, ctrl_DIV          : one-cycle start pulses (MULT has priority)
//   data_result, data_exception  : registered result / overflow-or-div0 flag
//   data_resultRDY               : one-cycle completion pulse
//   busy                         : high while an operation is in flight
module multdiv_unit (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        busy
);

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 5;

   typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

   state_t          r_state;
   state_t          w_next;
   logic            w_start;
   logic            w_last;

   logic [CW-1:0]   r_cnt;
   logic [2*W-1:0]  r_acc;
   logic [2*W-1:0]  r_mcand;
   logic [W-1:0]    r_mplier;
   logic [W-1:0]    r_rem;
   logic [W-1:0]    r_quo;
   logic [W-1:0]    r_dvsr;
   logic            r_neg;
   logic            r_dz;
   logic            r_ovf;

   logic [2*W-1:0]  w_addend;
   logic [2*W-1:0]  w_acc_nxt;
   logic            w_mult_ovf;
   logic [W:0]      w_rem_sh;
   logic [W:0]      w_diff;
   logic [W-1:0]    w_rem_nxt;
   logic [W-1:0]    w_quo_nxt;
   logic [W-1:0]    w_div_res;

   // State register
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic; start accepted only from IDLE/DONE
   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      w_last  = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            w_next = S_IDLE;
            if (ctrl_MULT) begin
               w_next  = S_MULT;
               w_start = 1'b1;
            end else if (ctrl_DIV) begin
               w_next  = S_DIV;
               w_start = 1'b1;
            end
         end
         S_MULT, S_DIV: begin
            if (r_cnt == CW'(W - 1)) begin
               w_next = S_DONE;
               w_last = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Multiply step: the final partial product carries negative weight
   always_comb begin
      w_addend   = r_mplier[0] ? r_mcand : '0;
      w_acc_nxt  = (r_cnt == CW'(W - 1)) ? (r_acc - w_addend) : (r_acc + w_addend);
      w_mult_ovf = !((&w_acc_nxt[2*W-1:W-1]) || !(|w_acc_nxt[2*W-1:W-1]));
   end

   // Restoring divide step; quotient bits shift into r_quo as dividend bits leave
   always_comb begin
      w_rem_sh  = {r_rem, r_quo[W-1]};
      w_diff    = w_rem_sh - {1'b0, r_dvsr};
      w_quo_nxt = {r_quo[W-2:0], ~w_diff[W]};
      w_rem_nxt = w_diff[W] ? w_rem_sh[W-1:0] : w_diff[W-1:0];
      w_div_res = r_dz ? '0 : (r_neg ? (W'(0) - w_quo_nxt) : w_quo_nxt);
   end

   // Datapath and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt          <= '0;
         r_acc          <= '0;
         r_mcand        <= '0;
         r_mplier       <= '0;
         r_rem          <= '0;
         r_quo          <= '0;
         r_dvsr         <= '0;
         r_neg          <= 1'b0;
         r_dz           <= 1'b0;
         r_ovf          <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
      end else begin
         data_resultRDY <= w_last;
         busy           <= (w_next == S_MULT) || (w_next == S_DIV);
         if (w_start) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{W{data_operandA[W-1]}}, data_operandA};
            r_mplier <= data_operandB;
            r_rem    <= '0;
            r_quo    <= data_operandA[W-1] ? (W'(0) - data_operandA) : data_operandA;
            r_dvsr   <= data_operandB[W-1] ? (W'(0) - data_operandB) : data_operandB;
            r_neg    <= data_operandA[W-1] ^ data_operandB[W-1];
            r_dz     <= (data_operandB == '0);
            r_ovf    <= (data_operandA == {1'b1, {(W-1){1'b0}}}) && (&data_operandB);
         end else if (r_state == S_MULT) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
         end else if (r_state == S_DIV) begin
            r_rem    <= w_rem_nxt;
            r_quo    <= w_quo_nxt;
            r_cnt    <= r_cnt + CW'(1);
         end
         if (w_last) begin
            if (r_state == S_MULT) begin
               data_result    <= w_acc_nxt[W-1:0];
               data_exception <= w_mult_ovf;
            end else begin
               data_result    <= w_div_res;
               data_exception <= r_dz | r_ovf;
            end
         end
      end
   end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed corner cases plus random
// multiply/divide operations compared against an arithmetic reference.
module tb_multdiv_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   multdiv_unit dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: exact signed product, overflow when outside the 32-bit range
   function automatic void ref_mult(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic e);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
   endfunction

   // Reference: truncating signed divide with div-by-zero and overflow cases
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e);
      longint q;
      if (b == 32'd0) begin
         r = 32'd0;
         e = 1'b1;
      end else begin
         q = longint'($signed(a)) / longint'($signed(b));
         r = q[31:0];
         e = (q > 64'sd2147483647);
      end
   endfunction

   // Drive a start pulse for one edge (called at a negedge); operands scrambled afterward
   task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      data_operandA = a;
      data_operandB = b;
      @(negedge clock);
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   // Wait for completion; k0 = edges already elapsed since the start edge
   task automatic await_done(input string tag, input int k0,
                             input logic [31:0] er, input logic ee);
      int k = k0;
      while (!data_resultRDY && k < 40) begin
         if (k > 0) check({tag, "_busy"}, 32'(busy), 32'd1);
         @(negedge clock);
         k++;
      end
      check({tag, "_latency"}, 32'(k), 32'd32);
      check({tag, "_result"}, data_result, er);
      check({tag, "_exc"}, 32'(data_exception), 32'(ee));
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
   endtask

   task automatic run_op(input string tag, input logic is_mult,
                         input logic [31:0] a, input logic [31:0] b);
      logic [31:0] er;
      logic        ee;
      if (is_mult) ref_mult(a, b, er, ee);
      else         ref_div(a, b, er, ee);
      issue(is_mult, !is_mult, a, b);
      check({tag, "_busy_start"}, 32'(busy), 32'd1);
      await_done(tag, 0, er, ee);
   endtask

   initial begin
      logic [31:0] a, b, er, last_r;
      logic        ee, saw_rdy;
      reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
      data_operandA = '0; data_operandB = '0;
      repeat (2) @(negedge clock);
      // Reset wins over a simultaneous start
      ctrl_MULT = 1'b1; data_operandA = 32'd5; data_operandB = 32'd6;
      @(negedge clock);
      ctrl_MULT = 1'b0;
      check("rst_result", data_result, 32'd0);
      check("rst_exc", 32'(data_exception), 32'd0);
      check("rst_rdy", 32'(data_resultRDY), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      check("rst_start_ignored", 32'(busy), 32'd0);

      run_op("mul_7x-6", 1'b1, 32'd7, 32'hFFFF_FFFA);
      check("mul_7x-6_val", data_result, 32'hFFFF_FFD6);
      @(negedge clock);
      check("done_to_idle_rdy", 32'(data_resultRDY), 32'd0);
      repeat (3) @(negedge clock);
      check("hold_result", data_result, 32'hFFFF_FFD6);

      run_op("mul_ovf", 1'b1, 32'h0001_0000, 32'h0001_0000);
      check("mul_ovf_val", {data_result[31:1], data_exception}, 32'h0000_0001);
      run_op("div_-7/2", 1'b0, 32'hFFFF_FFF9, 32'd2);
      check("div_-7/2_val", data_result, 32'hFFFF_FFFD);
      run_op("div_5/0", 1'b0, 32'd5, 32'd0);
      run_op("div_min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      check("div_min_val", data_result, 32'h8000_0000);
      // Back-to-back: start issued during the DONE cycle
      run_op("b2b", 1'b1, 32'd100, 32'hFFFF_FF9C);
      @(negedge clock);

      // ctrl_DIV during a running MULT is ignored
      ref_mult(32'd12345, 32'd678, er, ee);
      issue(1'b1, 1'b0, 32'd12345, 32'd678);
      repeat (9) @(negedge clock);
      issue(1'b0, 1'b1, 32'd1, 32'd1);
      await_done("ignore_div", 10, er, ee);
      @(negedge clock);

      // Both starts: multiply wins
      issue(1'b1, 1'b1, 32'd9, 32'd3);
      await_done("both", 0, 32'd27, 1'b0);
      @(negedge clock);

      // Reset mid-divide aborts with no completion pulse
      issue(1'b0, 1'b1, 32'd1000, 32'd7);
      repeat (14) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("abort_result", data_result, 32'd0);
      check("abort_exc", 32'(data_exception), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      saw_rdy = data_resultRDY;
      repeat (40) begin
         @(negedge clock);
         saw_rdy = saw_rdy | data_resultRDY;
      end
      check("abort_no_rdy", 32'(saw_rdy), 32'd0);
      run_op("mul_3x4", 1'b1, 32'd3, 32'd4);
      check("mul_3x4_val", data_result, 32'd12);

      // Random operations, some back-to-back, some with idle gaps
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'($signed(16'($urandom)));
            1: a = 32'($signed(12'($urandom)));
            2: if (i % 5 == 0) b = 32'd0;
            default: ;
         endcase
         run_op("rand", i[0], a, b);
         last_r = data_result;
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) @(negedge clock);
            check("rand_hold", data_result, last_r);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
